// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-side tagged memory bus initiator.
// Bus command and size encodings match the existing processor definitions.
package mem_bus_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_TAGS = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        CLIENT_IF = 1'b0,
        CLIENT_D  = 1'b1
    } MEM_CLIENT;

    typedef struct packed {
        logic      valid;
        MEM_CLIENT owner;
    } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Client request/response and memory-bus signal bundle for mem_bus_arbiter.
// The master modport is the arbiter; slave is the surrounding fetch/LSQ/memory.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              if_req_valid;
    logic [XLEN-1:0]   if_req_addr;
    logic              if_req_grant;
    logic              if_resp_valid;
    logic [63:0]       if_resp_data;

    logic              d_req_valid;
    BUS_COMMAND        d_req_cmd;
    logic [XLEN-1:0]   d_req_addr;
    logic [63:0]       d_req_data;
    MEM_SIZE           d_req_size;
    logic              d_req_grant;
    logic              d_resp_valid;
    logic [63:0]       d_resp_data;

    BUS_COMMAND        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    MEM_SIZE           proc2mem_size;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    modport master (
        input  if_req_valid, if_req_addr,
        output if_req_grant, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_cmd, d_req_addr, d_req_data, d_req_size,
        output d_req_grant, d_resp_valid, d_resp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        output if_req_valid, if_req_addr,
        input  if_req_grant, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_cmd, d_req_addr, d_req_data, d_req_size,
        input  d_req_grant, d_resp_valid, d_resp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// In-flight load tag table: one allocate port, one free port, population
// count and sticky error on double-allocate or return to an empty tag.
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  MEM_CLIENT        alloc_owner,
    input  logic             free_en,
    input  logic [TAG_W-1:0] free_tag,
    output logic             free_hit,
    output MEM_CLIENT        free_owner,
    output logic [TAG_W-1:0] count,
    output logic             error
);

    MEM_TAG_ENTRY     entry_q [NUM_TAGS];
    MEM_TAG_ENTRY     entry_d [NUM_TAGS];
    logic [TAG_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    // Free is applied before allocate so a same-tag return/grant pair leaves
    // the entry owned by the new client with the count unchanged.
    always_comb begin
        entry_d    = entry_q;
        count_d    = count_q;
        error_d    = error_q;
        free_hit   = 1'b0;
        free_owner = CLIENT_IF;
        if (free_en) begin
            if (entry_q[free_tag].valid) begin
                free_hit          = 1'b1;
                free_owner        = entry_q[free_tag].owner;
                entry_d[free_tag] = '0;
                count_d           = count_d - 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end
        if (alloc_en) begin
            if (entry_d[alloc_tag].valid) begin
                error_d = 1'b1;
            end else begin
                count_d = count_d + 1'b1;
            end
            entry_d[alloc_tag].valid = 1'b1;
            entry_d[alloc_tag].owner = alloc_owner;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign count = count_q;
    assign error = error_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and data clients onto the tagged memory bus and routes
// each tagged return back to the client that issued the load.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 15,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus,
    output logic [TAG_W-1:0]  outstanding_cnt,
    output logic              tag_error
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                if_resp_valid_q, if_resp_valid_d;
    logic                d_resp_valid_q, d_resp_valid_d;
    logic [63:0]         resp_data_q, resp_data_d;

    logic      table_full, d_is_load, d_cand, if_cand, if_win, d_win, accepted;
    logic      if_grant, d_grant, alloc_en, free_en, free_hit;
    MEM_CLIENT alloc_owner, free_owner;

    // Everything combinational is gated by reset so the bus idles while it is held.
    always_comb begin
        table_full = (outstanding_cnt == TAG_W'(MAX_OUTSTANDING));
        d_is_load  = (bus.d_req_cmd == BUS_LOAD);
        d_cand     = reset && bus.d_req_valid && (bus.d_req_cmd != BUS_NONE)
                     && !(d_is_load && table_full);
        if_cand    = reset && bus.if_req_valid && !table_full;
        if_win     = if_cand && ((starve_q == STARVE_W'(STARVE_LIMIT)) || !d_cand);
        d_win      = d_cand && !if_win;
        accepted   = (bus.mem2proc_response != '0);

        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = BYTE;
        if (if_win) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.if_req_addr;
            bus.proc2mem_size    = DOUBLE;
        end else if (d_win) begin
            bus.proc2mem_command = bus.d_req_cmd;
            bus.proc2mem_addr    = bus.d_req_addr;
            bus.proc2mem_data    = bus.d_req_data;
            bus.proc2mem_size    = bus.d_req_size;
        end

        if_grant    = if_win && accepted;
        d_grant     = d_win && accepted;
        alloc_en    = if_grant || (d_grant && d_is_load);
        alloc_owner = if_grant ? CLIENT_IF : CLIENT_D;
        free_en     = reset && (bus.mem2proc_tag != '0);

        starve_d = starve_q;
        if (if_grant) begin
            starve_d = '0;
        end else if (bus.if_req_valid && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end

        if_resp_valid_d = free_hit && (free_owner == CLIENT_IF);
        d_resp_valid_d  = free_hit && (free_owner == CLIENT_D);
        resp_data_d     = free_hit ? bus.mem2proc_data : resp_data_q;
    end

    mem_tag_table u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (bus.mem2proc_response),
        .alloc_owner (alloc_owner),
        .free_en     (free_en),
        .free_tag    (bus.mem2proc_tag),
        .free_hit    (free_hit),
        .free_owner  (free_owner),
        .count       (outstanding_cnt),
        .error       (tag_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q        <= '0;
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            resp_data_q     <= '0;
        end else begin
            starve_q        <= starve_d;
            if_resp_valid_q <= if_resp_valid_d;
            d_resp_valid_q  <= d_resp_valid_d;
            resp_data_q     <= resp_data_d;
        end
    end

    assign bus.if_req_grant  = if_grant;
    assign bus.d_req_grant   = d_grant;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.d_resp_valid  = d_resp_valid_q;
    assign bus.if_resp_data  = if_resp_valid_q ? resp_data_q : '0;
    assign bus.d_resp_data   = d_resp_valid_q ? resp_data_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, starvation, tag returns,
// stores, table-full masking, tag errors and mid-flight reset.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] outstanding_cnt;
    logic       tag_error;
    int         tests_run = 0;
    int         failed    = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.MAX_OUTSTANDING(15), .STARVE_LIMIT(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .outstanding_cnt (outstanding_cnt),
        .tag_error       (tag_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.if_req_valid      = 1'b0;
        bus.if_req_addr       = '0;
        bus.d_req_valid       = 1'b0;
        bus.d_req_cmd         = BUS_NONE;
        bus.d_req_addr        = '0;
        bus.d_req_data        = '0;
        bus.d_req_size        = BYTE;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic d_load(input logic [31:0] addr);
        bus.d_req_valid = 1'b1;
        bus.d_req_cmd   = BUS_LOAD;
        bus.d_req_addr  = addr;
        bus.d_req_size  = WORD;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        bus.if_req_valid = 1'b1;
        d_load(32'h100);
        bus.mem2proc_response = 4'd3;
        bus.mem2proc_tag = 4'd2;
        #1;
        tests_run++; if (bus.proc2mem_command !== BUS_NONE) begin failed++; $display("FAIL reset_cmd: got %0d want 0", bus.proc2mem_command); end
        tests_run++; if ({bus.if_req_grant, bus.d_req_grant} !== 2'b00) begin failed++; $display("FAIL reset_grants: got %b want 00", {bus.if_req_grant, bus.d_req_grant}); end
        tick();
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL reset_cnt: got %0d want 0", outstanding_cnt); end
        tests_run++; if ({tag_error, bus.if_resp_valid, bus.d_resp_valid} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b want 000", {tag_error, bus.if_resp_valid, bus.d_resp_valid}); end
        idle();
        reset = 1'b1;
        tick();
    endtask

    // Data wins while fetch starves; after four denials starve_cnt hits the limit.
    task automatic test_arbitration();
        idle();
        d_load(32'h100);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h200;
        for (int k = 1; k <= 4; k++) begin
            bus.mem2proc_response = 4'(k);
            #1;
            tests_run++; if ({bus.if_req_grant, bus.d_req_grant} !== 2'b01) begin failed++; $display("FAIL arb_data_cycle%0d: got %b want 01", k, {bus.if_req_grant, bus.d_req_grant}); end
            tests_run++; if (bus.proc2mem_addr !== 32'h100) begin failed++; $display("FAIL arb_data_addr%0d: got %h want 100", k, bus.proc2mem_addr); end
            tick();
        end
        bus.mem2proc_response = 4'd5;
        #1;
        tests_run++; if ({bus.if_req_grant, bus.d_req_grant} !== 2'b10) begin failed++; $display("FAIL arb_fetch_grant: got %b want 10", {bus.if_req_grant, bus.d_req_grant}); end
        tests_run++; if (bus.proc2mem_addr !== 32'h200 || bus.proc2mem_size !== DOUBLE || bus.proc2mem_command !== BUS_LOAD) begin failed++; $display("FAIL arb_fetch_bus: got addr %h size %0d cmd %0d want 200/3/1", bus.proc2mem_addr, bus.proc2mem_size, bus.proc2mem_command); end
        tick();
        idle();
        tests_run++; if (outstanding_cnt !== 4'd5) begin failed++; $display("FAIL arb_cnt: got %0d want 5", outstanding_cnt); end
        for (int k = 1; k <= 5; k++) begin
            bus.mem2proc_tag  = 4'(k);
            bus.mem2proc_data = 64'(k) * 64'h11;
            tick();
            tests_run++; if ({bus.if_resp_valid, bus.d_resp_valid} !== ((k == 5) ? 2'b10 : 2'b01)) begin failed++; $display("FAIL arb_route_tag%0d: got %b", k, {bus.if_resp_valid, bus.d_resp_valid}); end
        end
        bus.mem2proc_tag = '0;
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL arb_drain_cnt: got %0d want 0", outstanding_cnt); end
        tick();
    endtask

    task automatic test_fetch_return();
        idle();
        bus.if_req_valid      = 1'b1;
        bus.if_req_addr       = 32'h40;
        bus.mem2proc_response = 4'd5;
        #1;
        tests_run++; if (bus.if_req_grant !== 1'b1) begin failed++; $display("FAIL fetch_grant: got %b want 1", bus.if_req_grant); end
        tick();
        idle();
        tests_run++; if (outstanding_cnt !== 4'd1) begin failed++; $display("FAIL fetch_cnt_alloc: got %0d want 1", outstanding_cnt); end
        tick();
        tick();
        bus.mem2proc_tag  = 4'd5;
        bus.mem2proc_data = 64'hDEADBEEF;
        tick();
        bus.mem2proc_tag = '0;
        tests_run++; if (bus.if_resp_valid !== 1'b1 || bus.d_resp_valid !== 1'b0) begin failed++; $display("FAIL fetch_resp_valid: got if=%b d=%b want 1/0", bus.if_resp_valid, bus.d_resp_valid); end
        tests_run++; if (bus.if_resp_data !== 64'hDEADBEEF) begin failed++; $display("FAIL fetch_resp_data: got %h want deadbeef", bus.if_resp_data); end
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL fetch_cnt_free: got %0d want 0", outstanding_cnt); end
        tick();
        tests_run++; if (bus.if_resp_valid !== 1'b0) begin failed++; $display("FAIL fetch_resp_pulse: got %b want 0", bus.if_resp_valid); end
    endtask

    task automatic test_store_and_reject();
        idle();
        d_load(32'h80);
        #1;
        tests_run++; if (bus.d_req_grant !== 1'b0 || bus.proc2mem_command !== BUS_LOAD) begin failed++; $display("FAIL reject_grant: got grant %b cmd %0d want 0/1", bus.d_req_grant, bus.proc2mem_command); end
        tick();
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL reject_cnt: got %0d want 0", outstanding_cnt); end
        bus.d_req_cmd         = BUS_STORE;
        bus.d_req_addr        = 32'h88;
        bus.d_req_data        = 64'h1234_5678_9ABC_DEF0;
        bus.d_req_size        = DOUBLE;
        bus.mem2proc_response = 4'd7;
        #1;
        tests_run++; if (bus.d_req_grant !== 1'b1 || bus.proc2mem_command !== BUS_STORE) begin failed++; $display("FAIL store_grant: got grant %b cmd %0d want 1/2", bus.d_req_grant, bus.proc2mem_command); end
        tests_run++; if (bus.proc2mem_data !== 64'h1234_5678_9ABC_DEF0) begin failed++; $display("FAIL store_data: got %h", bus.proc2mem_data); end
        tick();
        idle();
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL store_cnt: got %0d want 0", outstanding_cnt); end
        tick();
        tests_run++; if (bus.d_resp_valid !== 1'b0 || tag_error !== 1'b0) begin failed++; $display("FAIL store_noresp: got resp %b err %b want 0/0", bus.d_resp_valid, tag_error); end
    endtask

    // Return of the old owner and grant to the new owner on tag 4 in one cycle.
    task automatic test_same_tag();
        idle();
        bus.if_req_valid      = 1'b1;
        bus.mem2proc_response = 4'd4;
        tick();
        idle();
        d_load(32'h300);
        bus.mem2proc_response = 4'd4;
        bus.mem2proc_tag      = 4'd4;
        bus.mem2proc_data     = 64'hAAAA;
        #1;
        tests_run++; if (bus.d_req_grant !== 1'b1) begin failed++; $display("FAIL same_tag_grant: got %b want 1", bus.d_req_grant); end
        tick();
        idle();
        tests_run++; if (bus.if_resp_valid !== 1'b1 || bus.if_resp_data !== 64'hAAAA) begin failed++; $display("FAIL same_tag_old_owner: got %b %h want 1 aaaa", bus.if_resp_valid, bus.if_resp_data); end
        tests_run++; if (outstanding_cnt !== 4'd1 || tag_error !== 1'b0) begin failed++; $display("FAIL same_tag_cnt_err: got %0d %b want 1 0", outstanding_cnt, tag_error); end
        bus.mem2proc_tag  = 4'd4;
        bus.mem2proc_data = 64'hBBBB;
        tick();
        bus.mem2proc_tag = '0;
        tests_run++; if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 64'hBBBB || bus.if_resp_valid !== 1'b0) begin failed++; $display("FAIL same_tag_new_owner: got d=%b %h if=%b want 1 bbbb 0", bus.d_resp_valid, bus.d_resp_data, bus.if_resp_valid); end
        tests_run++; if (outstanding_cnt !== 4'd0) begin failed++; $display("FAIL same_tag_drain: got %0d want 0", outstanding_cnt); end
    endtask

    task automatic test_full();
        idle();
        d_load(32'h500);
        for (int k = 1; k <= 15; k++) begin
            bus.mem2proc_response = 4'(k);
            tick();
        end
        tests_run++; if (outstanding_cnt !== 4'd15) begin failed++; $display("FAIL full_cnt: got %0d want 15", outstanding_cnt); end
        bus.if_req_valid      = 1'b1;
        bus.mem2proc_response = 4'd1;
        #1;
        tests_run++; if (bus.proc2mem_command !== BUS_NONE || bus.proc2mem_addr !== 32'h0) begin failed++; $display("FAIL full_masked: got cmd %0d addr %h want 0 0", bus.proc2mem_command, bus.proc2mem_addr); end
        tests_run++; if ({bus.if_req_grant, bus.d_req_grant} !== 2'b00) begin failed++; $display("FAIL full_no_grant: got %b want 00", {bus.if_req_grant, bus.d_req_grant}); end
        bus.d_req_cmd  = BUS_STORE;
        bus.d_req_data = 64'h55;
        #1;
        tests_run++; if (bus.proc2mem_command !== BUS_STORE || bus.d_req_grant !== 1'b1) begin failed++; $display("FAIL full_store: got cmd %0d grant %b want 2 1", bus.proc2mem_command, bus.d_req_grant); end
        tick();
        idle();
        for (int k = 1; k <= 15; k++) begin
            bus.mem2proc_tag = 4'(k);
            tick();
            tests_run++; if (bus.d_resp_valid !== 1'b1) begin failed++; $display("FAIL full_return_tag%0d: got %b want 1", k, bus.d_resp_valid); end
        end
        bus.mem2proc_tag = '0;
        tests_run++; if (outstanding_cnt !== 4'd0 || tag_error !== 1'b0) begin failed++; $display("FAIL full_drain: got %0d %b want 0 0", outstanding_cnt, tag_error); end
        tick();
    endtask

    task automatic test_tag_error();
        idle();
        bus.mem2proc_tag  = 4'd9;
        bus.mem2proc_data = 64'h99;
        tick();
        bus.mem2proc_tag = '0;
        tests_run++; if (tag_error !== 1'b1) begin failed++; $display("FAIL tag_err_set: got %b want 1", tag_error); end
        tests_run++; if ({bus.if_resp_valid, bus.d_resp_valid} !== 2'b00) begin failed++; $display("FAIL tag_err_drop: got %b want 00", {bus.if_resp_valid, bus.d_resp_valid}); end
        tick();
        tick();
        tests_run++; if (tag_error !== 1'b1) begin failed++; $display("FAIL tag_err_sticky: got %b want 1", tag_error); end
    endtask

    task automatic test_reset_midflight();
        idle();
        d_load(32'h600);
        for (int k = 1; k <= 3; k++) begin
            bus.mem2proc_response = 4'(k);
            tick();
        end
        tests_run++; if (outstanding_cnt !== 4'd3) begin failed++; $display("FAIL mid_cnt: got %0d want 3", outstanding_cnt); end
        bus.mem2proc_response = 4'd6;
        reset = 1'b0;
        #1;
        tests_run++; if (bus.proc2mem_command !== BUS_NONE || bus.proc2mem_addr !== 32'h0 || bus.d_req_grant !== 1'b0) begin failed++; $display("FAIL mid_bus_idle: got cmd %0d addr %h grant %b", bus.proc2mem_command, bus.proc2mem_addr, bus.d_req_grant); end
        tests_run++; if (outstanding_cnt !== 4'd0 || tag_error !== 1'b0) begin failed++; $display("FAIL mid_state_clear: got cnt %0d err %b want 0 0", outstanding_cnt, tag_error); end
        tick();
        idle();
        reset = 1'b1;
        tick();
        bus.mem2proc_tag = 4'd2;
        tick();
        bus.mem2proc_tag = '0;
        tests_run++; if (tag_error !== 1'b1 || bus.d_resp_valid !== 1'b0) begin failed++; $display("FAIL mid_stale_return: got err %b resp %b want 1 0", tag_error, bus.d_resp_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arbitration();
        test_fetch_return();
        test_store_and_reject();
        test_same_tag();
        test_full();
        test_tag_error();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
